// File: rtl/vreg_write_arbiter.sv
// Vector RF write-port arbiter: in-order pipeline writeback vs. a FIFO of conv results.
// Latency: wb -> rf_we in 1 cycle; conv -> rf_we in 2 cycles on an idle port.
// Backpressure: conv_ready low when FIFO full (extra writes dropped, overflow_err); pipe_stall on forced conv grant.
module vreg_write_arbiter #(
    parameter int  LENGTH     = 16,
    parameter int  INT8       = 8,
    parameter int  DEPTH      = 4,
    parameter int  MAX_STARVE = 3,
    localparam int DW         = LENGTH * INT8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_valid,
    input  logic [4:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          pipe_stall,
    input  logic          conv_write,
    input  logic [4:0]    conv_addr,
    input  logic [DW-1:0] conv_result,
    output logic          conv_ready,
    input  logic [4:0]    query_addr,
    output logic          pend_hit,
    output logic          rf_we,
    output logic [4:0]    rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          overflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(MAX_STARVE + 1);

    typedef struct packed {
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        fifo_mem [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;
    logic          fifo_nonempty;
    logic          force_conv;
    logic          grant_conv;
    logic          grant_wb;
    logic          enq;

    assign fifo_nonempty = (count != '0);
    assign conv_ready    = (count != CW'(DEPTH));
    assign force_conv    = fifo_nonempty && (starve_cnt == SW'(MAX_STARVE));
    assign grant_conv    = force_conv || (!wb_valid && fifo_nonempty);
    assign grant_wb      = !force_conv && wb_valid;
    assign pipe_stall    = force_conv;
    // A full FIFO refuses the write even if the head drains this same cycle.
    assign enq           = conv_write && conv_ready;
    assign count_nxt     = count + CW'(enq) - CW'(grant_conv);

    always_comb begin
        starve_nxt = starve_cnt;
        if (grant_conv) begin
            starve_nxt = '0;
        end else if (grant_wb && fifo_nonempty && (starve_cnt != SW'(MAX_STARVE))) begin
            starve_nxt = starve_cnt + SW'(1);
        end
        if (count_nxt == '0) begin
            starve_nxt = '0;
        end
    end

    always_comb begin
        pend_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (fifo_mem[i].addr == query_addr)) begin
                pend_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            starve_cnt   <= '0;
            ent_vld      <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            overflow_err <= 1'b0;
        end else begin
            count      <= count_nxt;
            starve_cnt <= starve_nxt;
            if (enq) begin
                wr_ptr          <= wr_ptr + AW'(1);
                ent_vld[wr_ptr] <= 1'b1;
            end
            if (grant_conv) begin
                rd_ptr          <= rd_ptr + AW'(1);
                ent_vld[rd_ptr] <= 1'b0;
            end
            if (conv_write && !conv_ready) begin
                overflow_err <= 1'b1;
            end
            rf_we <= grant_conv || grant_wb;
            if (grant_conv) begin
                rf_waddr <= fifo_mem[rd_ptr].addr;
                rf_wdata <= fifo_mem[rd_ptr].data;
            end else if (grant_wb) begin
                rf_waddr <= wb_addr;
                rf_wdata <= wb_data;
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by ent_vld.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_mem[wr_ptr] <= '{addr: conv_addr, data: conv_result};
        end
    end

endmodule

// File: tb/tb_vreg_write_arbiter.sv
// Scoreboard bench for vreg_write_arbiter: expected RF writes queued per scenario, checked as rf_we fires.
module tb_vreg_write_arbiter;
    localparam int DW = 128;

    typedef struct {
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_valid;
    logic [4:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          pipe_stall;
    logic          conv_write;
    logic [4:0]    conv_addr;
    logic [DW-1:0] conv_result;
    logic          conv_ready;
    logic [4:0]    query_addr;
    logic          pend_hit;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          overflow_err;

    wr_t sb[$];
    int  vectors     = 0;
    int  miscompares = 0;

    vreg_write_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .pipe_stall   (pipe_stall),
        .conv_write   (conv_write),
        .conv_addr    (conv_addr),
        .conv_result  (conv_result),
        .conv_ready   (conv_ready),
        .query_addr   (query_addr),
        .pend_hit     (pend_hit),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic push_exp(input logic [4:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wb_valid    = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        conv_write  = 1'b0;
        conv_addr   = '0;
        conv_result = '0;
    endtask

    // Every RF write must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL rf_write_unexpected: got addr=%0d data=%h, expected no write", rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
                    miscompares++;
                    $display("FAIL rf_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             rf_waddr, rf_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic test_reset;
        reset = 1'b1;
        idle();
        query_addr = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== '0) begin
            miscompares++;
            $display("FAIL reset_rf: got we=%b addr=%0d data=%h, expected 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        vectors++;
        if (conv_ready !== 1'b1 || pend_hit !== 1'b0 || pipe_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_comb: got ready=%b hit=%b stall=%b, expected 1/0/0", conv_ready, pend_hit, pipe_stall);
        end
        vectors++;
        if (overflow_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ovf: got %b, expected 0", overflow_err);
        end
        next_cycle();
    endtask

    task automatic test_wb_write;
        wb_valid = 1'b1;
        wb_addr  = 5'd7;
        wb_data  = pat(8'hAA);
        push_exp(5'd7, pat(8'hAA));
        @(negedge clk);
        vectors++;
        if (pipe_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL wb_stall: got %b, expected 0", pipe_stall);
        end
        next_cycle();
        idle();
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== pat(8'hAA)) begin
            miscompares++;
            $display("FAIL wb_latency: got we=%b addr=%0d, expected we=1 addr=7", rf_we, rf_waddr);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd7) begin
            miscompares++;
            $display("FAIL wb_hold: got we=%b addr=%0d, expected we=0 addr=7", rf_we, rf_waddr);
        end
        next_cycle();
    endtask

    task automatic test_conv_idle;
        query_addr  = 5'd3;
        conv_write  = 1'b1;
        conv_addr   = 5'd3;
        conv_result = pat(8'h33);
        push_exp(5'd3, pat(8'h33));
        @(negedge clk);
        vectors++;
        if (pend_hit !== 1'b0 || conv_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL conv_c1: got hit=%b ready=%b, expected 0/1", pend_hit, conv_ready);
        end
        next_cycle();
        idle();
        @(negedge clk);
        vectors++;
        if (pend_hit !== 1'b1 || rf_we !== 1'b0) begin
            miscompares++;
            $display("FAIL conv_c2: got hit=%b we=%b, expected 1/0", pend_hit, rf_we);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (pend_hit !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd3) begin
            miscompares++;
            $display("FAIL conv_c3: got hit=%b we=%b addr=%0d, expected 0/1/3", pend_hit, rf_we, rf_waddr);
        end
        next_cycle();
        next_cycle();
    endtask

    task automatic test_starvation;
        query_addr = 5'd3;
        for (int k = 0; k < 4; k++) push_exp(5'(10 + k), pat(8'(8'h10 + k)));
        push_exp(5'd3, pat(8'hC3));
        push_exp(5'd14, pat(8'h14));
        conv_write  = 1'b1;
        conv_addr   = 5'd3;
        conv_result = pat(8'hC3);
        for (int k = 0; k < 5; k++) begin
            wb_valid = 1'b1;
            wb_addr  = 5'(10 + k);
            wb_data  = pat(8'(8'h10 + k));
            @(negedge clk);
            vectors++;
            if (pipe_stall !== (k == 4)) begin
                miscompares++;
                $display("FAIL starve_stall_c%0d: got %b, expected %b", k, pipe_stall, (k == 4));
            end
            vectors++;
            if (pend_hit !== (k != 0)) begin
                miscompares++;
                $display("FAIL starve_hit_c%0d: got %b, expected %b", k, pend_hit, (k != 0));
            end
            next_cycle();
            conv_write = 1'b0;
        end
        // W4 is still held after the forced cycle.
        @(negedge clk);
        vectors++;
        if (pipe_stall !== 1'b0 || pend_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL starve_resume: got stall=%b hit=%b, expected 0/0", pipe_stall, pend_hit);
        end
        next_cycle();
        idle();
        repeat (2) next_cycle();
    endtask

    task automatic test_overflow;
        for (int k = 0; k < 4; k++) push_exp(5'(8 + k), pat(8'(8'h50 + k)));
        push_exp(5'd24, pat(8'hA0));
        push_exp(5'd12, pat(8'h54));
        for (int k = 1; k < 4; k++) push_exp(5'(24 + k), pat(8'(8'hA0 + k)));
        query_addr = 5'd28;
        for (int k = 0; k < 5; k++) begin
            conv_write  = 1'b1;
            conv_addr   = 5'(24 + k);
            conv_result = pat(8'(8'hA0 + k));
            wb_valid    = 1'b1;
            wb_addr     = 5'(8 + k);
            wb_data     = pat(8'(8'h50 + k));
            @(negedge clk);
            vectors++;
            if (conv_ready !== (k < 4) || pipe_stall !== (k == 4)) begin
                miscompares++;
                $display("FAIL ovf_c%0d: got ready=%b stall=%b, expected %b/%b",
                         k, conv_ready, pipe_stall, (k < 4), (k == 4));
            end
            next_cycle();
        end
        conv_write = 1'b0;
        @(negedge clk);
        vectors++;
        if (overflow_err !== 1'b1 || pend_hit !== 1'b0 || pipe_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_flag: got err=%b hit=%b stall=%b, expected 1/0/0", overflow_err, pend_hit, pipe_stall);
        end
        next_cycle();
        idle();
        repeat (4) next_cycle();
        // Two three-entry fills move the pointers across the wrap point.
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < 3; j++) push_exp(5'd30, pat(8'(8'h60 + 3 * f + j)));
            for (int j = 0; j < 3; j++) push_exp(5'(1 + 3 * f + j), pat(8'(8'hB0 + 3 * f + j)));
            for (int j = 0; j < 3; j++) begin
                conv_write  = 1'b1;
                conv_addr   = 5'(1 + 3 * f + j);
                conv_result = pat(8'(8'hB0 + 3 * f + j));
                wb_valid    = 1'b1;
                wb_addr     = 5'd30;
                wb_data     = pat(8'(8'h60 + 3 * f + j));
                next_cycle();
            end
            idle();
            for (int d = 0; d < 4; d++) begin
                query_addr = (d == 1) ? 5'(1 + 3 * f) : 5'(3 + 3 * f);
                @(negedge clk);
                vectors++;
                if (pend_hit !== (d != 1 && d != 3)) begin
                    miscompares++;
                    $display("FAIL wrap_hit_f%0d_d%0d: got %b, expected %b", f, d, pend_hit, (d != 1 && d != 3));
                end
                next_cycle();
            end
        end
        vectors++;
        if (overflow_err !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_sticky: got %b, expected 1", overflow_err);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid;
        push_exp(5'd2, pat(8'h22));
        push_exp(5'd4, pat(8'h44));
        for (int k = 0; k < 2; k++) begin
            conv_write  = 1'b1;
            conv_addr   = 5'(20 + k);
            conv_result = pat(8'(8'hE0 + k));
            wb_valid    = 1'b1;
            wb_addr     = 5'(2 + 2 * k);
            wb_data     = pat(8'(8'h22 * (k + 1)));
            query_addr  = 5'd20;
            @(negedge clk);
            vectors++;
            if (pend_hit !== (k == 1)) begin
                miscompares++;
                $display("FAIL rstmid_hit_c%0d: got %b, expected %b", k, pend_hit, (k == 1));
            end
            next_cycle();
        end
        reset       = 1'b1;
        wb_valid    = 1'b0;
        conv_write  = 1'b1;
        conv_addr   = 5'd22;
        conv_result = pat(8'hE2);
        query_addr  = 5'd21;
        @(negedge clk);
        vectors++;
        if (pend_hit !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pre: got hit=%b, expected 1", pend_hit);
        end
        next_cycle();
        reset = 1'b0;
        idle();
        for (int k = 0; k < 3; k++) begin
            query_addr = 5'(20 + k);
            @(negedge clk);
            vectors++;
            if (pend_hit !== 1'b0 || conv_ready !== 1'b1 || rf_we !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_q%0d: got hit=%b ready=%b we=%b, expected 0/1/0", k, pend_hit, conv_ready, rf_we);
            end
            if (k == 0) begin
                vectors++;
                if (overflow_err !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== '0) begin
                    miscompares++;
                    $display("FAIL rstmid_regs: got err=%b addr=%0d, expected 0/0", overflow_err, rf_waddr);
                end
            end
            next_cycle();
        end
        repeat (4) next_cycle();
    endtask

    initial begin
        test_reset();
        test_wb_write();
        test_conv_idle();
        test_starvation();
        test_overflow();
        test_reset_mid();
        repeat (2) next_cycle();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drained: got %0d outstanding writes, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vreg_write_arbiter.md
# vreg_write_arbiter

Arbitrates the single vector-register-file write port between two writers: the pipeline's vector writeback (post Execute/Memory, in program order) and the convolution engine's asynchronous result stream. Convolution writes are buffered in a small FIFO and drained when the port is idle. An anti-starvation counter stalls the pipeline when conv writes wait too long. The block also exposes a pending-write lookup so decode can interlock on registers with queued conv results.

## Interface
- `LENGTH`, 16, vector lanes
- `INT8`, 8, bits per lane; data width `DW = LENGTH*INT8` (128)
- `DEPTH`, 4, conv FIFO entries (power of two, ≥2)
- `MAX_STARVE`, 3, consecutive wb-won cycles with a non-empty FIFO before conv is forced
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `wb_valid` in 1: pipeline vector writeback request
- `wb_addr` in 5: destination vector register
- `wb_data` in DW: writeback data
- `pipe_stall` out 1: combinational; wb not accepted this cycle, upstream holds wb_* stable
- `conv_write` in 1: conv result valid
- `conv_addr` in 5: conv destination register
- `conv_result` in DW: conv data
- `conv_ready` out 1: combinational, `count != DEPTH`
- `query_addr` in 5: decode source/destination register lookup
- `pend_hit` out 1: combinational; a valid FIFO entry targets `query_addr`
- `rf_we` out 1: registered write enable to vector RF
- `rf_waddr` out 5: registered write address
- `rf_wdata` out DW: registered write data
- `overflow_err` out 1: sticky; a conv write was presented while `conv_ready`=0

## Operation
- FIFO: circular, `wr_ptr`/`rd_ptr` are log2(DEPTH) bits and wrap modulo DEPTH. `count` is 0..DEPTH. Each entry holds {addr, data, valid}.
- Enqueue when `conv_write && conv_ready`. When full, `conv_ready`=0 and nothing is enqueued, even if a dequeue happens the same cycle.
- `conv_write` while not ready: the data is dropped and `overflow_err` sets. It clears only on reset.
- Per-cycle grant, evaluated in priority order:
  1. `force = (count!=0) && (starve_cnt==MAX_STARVE)`: grant conv head, `pipe_stall`=1, `starve_cnt`←0.
  2. else `wb_valid`: grant wb, `pipe_stall`=0. If `count!=0`, `starve_cnt`←min(starve_cnt+1, MAX_STARVE).
  3. else `count!=0`: grant conv head, `starve_cnt`←0.
  4. else: no grant.
- `starve_cnt`←0 whenever `count`==0 at the clock edge (after dequeue accounting). `pipe_stall` is 0 whenever `force`=0, independent of `wb_valid`.
- Conv grant dequeues the head. The entry's valid bit clears on the same edge.
- Output register: on a grant, `rf_we`←1 with the granted addr/data. With no grant, `rf_we`←0 and `rf_waddr`/`rf_wdata` hold their previous values.
- `pend_hit`: OR over valid entries of (`entry.addr == query_addr`). The head entry remains a hit until the cycle its dequeue edge occurs.
- Simultaneous enqueue and dequeue with `0<count<DEPTH`: `count` is unchanged and both pointers advance.
- No write ordering is enforced between the two sources. Decode must use `pend_hit` to avoid WAW/RAW hazards with queued conv results.

## Timing
- Reset (synchronous) drives:
  - outputs: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `overflow_err`=0
  - state: `count`=0, pointers=0, `starve_cnt`=0, all entry valid=0
  - combinational outputs therefore: `conv_ready`=1, `pend_hit`=0, `pipe_stall`=0
- Reset asserted mid-operation discards all queued conv entries and wins over any same-cycle enqueue or grant.
- Wb latency: `wb_valid` at cycle N with no force → `rf_we`=1 at N+1.
- Conv latency, idle port: `conv_write` at N → entry visible at N+1 → granted at N+1 → `rf_we`=1 at N+2.
- Forced grant: `pipe_stall`=1 in cycle N. The held wb is granted at N+1 unless forced again; `starve_cnt` is 0, so it cannot be.
- Sustained throughput: one RF write per cycle.

## Test plan
- Reset, then idle: `rf_we`=0, `conv_ready`=1, `pend_hit`=0, `overflow_err`=0.
- `wb_valid`=1, `wb_addr`=7, `wb_data`=0xAA..AA at cycle 1 → `rf_we`=1, `rf_waddr`=7, `rf_wdata`=0xAA..AA at cycle 2, then `rf_we`=0.
- `conv_write` addr=3 at cycle 1 with `wb_valid`=0:
  - `pend_hit` (query 3) =1 in cycle 2
  - `rf_we`=1, `rf_waddr`=3 at cycle 3
  - `pend_hit`=0 from cycle 3
- Starvation: one conv entry queued, `wb_valid` held high continuously → wb granted 3 cycles, then `pipe_stall`=1 for 1 cycle with conv written, then wb resumes with the held data.
- Overflow: 5 back-to-back `conv_write` with `wb_valid` high and MAX_STARVE=3 → `conv_ready`=0 once 4 entries are queued, the 5th is dropped, `overflow_err`=1 (sticky). The 4 entries drain in order, with pointer wrap checked by 2 subsequent fills.
- Reset asserted with 2 entries queued → next cycle `count`=0, `rf_we`=0, `pend_hit`=0 for both addresses, and no queued write ever reaches the RF.
